// File: rtl/adsr_envelope_pkg.sv
// Shared constants for the ADSR envelope block: state encodings and sample/envelope limits.
package adsr_envelope_pkg;

    // State encodings are fixed numeric values so the state port stays legacy-compatible.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ATTACK  = 3'd1;
    localparam logic [2:0] ST_DECAY   = 3'd2;
    localparam logic [2:0] ST_SUSTAIN = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    // Unsigned sample midline (silence) and full-scale envelope.
    localparam logic [7:0] MIDLINE = 8'd128;
    localparam logic [7:0] ENV_MAX = 8'd255;

endpackage

// File: rtl/adsr_envelope_env_tick_gen.sv
// Envelope prescaler: free-running TICK_DIV-bit counter, one-clock tick when it is all ones.
module env_tick_gen #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    logic [TICK_DIV-1:0] cnt_q;

    // Counter wraps naturally from all ones back to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_q + TICK_DIV'(1);
    end

    assign tick = (cnt_q == '1);

endmodule

// File: rtl/adsr_envelope.sv
// Gated ADSR amplitude envelope applied to an 8-bit unsigned sample stream (midline 128).
// Optional build macro ADSR_EXP_RELEASE_EN selects an exponential release
// (env -= (env>>3)+1 per tick, release_rate ignored) instead of the linear one.
module adsr_envelope
    import adsr_envelope_pkg::*;
#(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       gate,
    input  logic [7:0] sample_in,
    input  logic [7:0] attack_rate,
    input  logic [7:0] decay_rate,
    input  logic [7:0] sustain_level,
    input  logic [7:0] release_rate,
    output logic [7:0] sample_out,
    output logic [7:0] env_level,
    output logic [2:0] state,
    output logic       busy
);

    logic              tick;
    logic [2:0]        state_q, state_d;
    logic [7:0]        env_q, env_d;
    logic [7:0]        sample_q, sample_d;
    logic [8:0]        attack_sum;
    logic [8:0]        decay_diff;
    logic [8:0]        rel_step;
    logic              gate_on, gate_off;
    logic signed [8:0]  smp_centered;
    logic signed [16:0] smp_product;

    env_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Next state / envelope: gate edges take priority over the tick update.
    always_comb begin
        state_d    = state_q;
        env_d      = env_q;
        attack_sum = {1'b0, env_q} + {1'b0, attack_rate};
        decay_diff = {1'b0, env_q} - {1'b0, decay_rate};
`ifdef ADSR_EXP_RELEASE_EN
        rel_step   = {1'b0, (env_q >> 3)} + 9'd1;
`else
        rel_step   = {1'b0, release_rate};
`endif
        gate_on  = gate  && (state_q == ST_IDLE || state_q == ST_RELEASE);
        gate_off = !gate && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                             state_q == ST_SUSTAIN);

        if (gate_on) begin
            state_d = ST_ATTACK;
        end else if (gate_off) begin
            state_d = ST_RELEASE;
        end else if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    env_d = '0;
                end
                ST_ATTACK: begin
                    if (attack_sum >= {1'b0, ENV_MAX}) begin
                        env_d   = ENV_MAX;
                        state_d = ST_DECAY;
                    end else begin
                        env_d = attack_sum[7:0];
                    end
                end
                ST_DECAY: begin
                    // Bit 8 of the difference flags an underflow past zero.
                    if (decay_diff[8] || (decay_diff[7:0] <= sustain_level)) begin
                        env_d   = sustain_level;
                        state_d = ST_SUSTAIN;
                    end else begin
                        env_d = decay_diff[7:0];
                    end
                end
                ST_SUSTAIN: begin
                    env_d = sustain_level;
                end
                ST_RELEASE: begin
                    if ({1'b0, env_q} <= rel_step) begin
                        env_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        env_d = env_q - rel_step[7:0];
                    end
                end
                default: begin
                    env_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Scaler: signed deviation from midline times envelope, divided by 256.
    always_comb begin
        smp_centered = $signed({1'b0, sample_in}) - 9'sd128;
        smp_product  = 17'(smp_centered) * 17'($signed({1'b0, env_q}));
        // Shifted product is within -128..126, so modulo-256 addition of the midline is exact.
        sample_d     = MIDLINE + 8'(smp_product >>> 8);
    end

    // State, envelope and scaled sample registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            env_q    <= '0;
            sample_q <= MIDLINE;
        end else begin
            state_q  <= state_d;
            env_q    <= env_d;
            sample_q <= sample_d;
        end
    end

    assign sample_out = sample_q;
    assign env_level  = env_q;
    assign state      = state_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
